quant_array: RTL and testbench
==============================

Name: quant_array

Overview:
- Per-filter requantization stage directly upstream of the output packer.
- Takes NUM_FILTERS signed 32-bit convolution accumulators per pixel and applies per-filter bias, per-filter scale, optional leaky ReLU, a rounding shift and int8 saturation.
- Presents 64 int8 results plus valid to the packer.
- Honours the packer's ready back-pressure through a 3-stage stall-able pipeline.

Parameters:
- NUM_FILTERS, 64, number of parallel filter lanes.
- ACC_W, 32, accumulator width (signed).
- SCALE_W, 16, per-filter multiplier width (unsigned).
- SHIFT_W, 5, global right-shift width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous assert, active-low
- acc_in  in  ACC_W x NUM_FILTERS  signed accumulators, lane i = filter i
- valid_in  in  1  acc_in and last_in valid
- ready_out  out  1  stage accepts a beat this cycle
- last_in  in  1  last pixel of tile, travels with the beat
- pixel_results  out  8 x NUM_FILTERS  int8 results, lane i = filter i
- valid_out  out  1  pixel_results valid
- ready_in  in  1  downstream (packer) ready
- last_out  out  1  last_in delayed with its beat
- cfg_we  in  1  write per-filter config
- cfg_addr  in  clog2(NUM_FILTERS)  filter index
- cfg_bias  in  ACC_W  signed bias
- cfg_scale  in  SCALE_W  unsigned scale
- cfg_shift  in  SHIFT_W  global shift, static while busy
- cfg_leaky  in  1  global leaky ReLU enable, static while busy
- busy  out  1  any pipeline stage holds a valid beat

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n); all flops clear immediately on assertion.
- Reset values:
  - valid_out=0, last_out=0, pixel_results=0, busy=0.
  - All stage valids 0.
  - bias regs=0, scale regs=1.
  - ready_out=1 after reset.
- Pipeline enable: en = ready_in || !valid_s3. ready_out = en.
  - A beat is accepted when valid_in && en.
  - All three stages advance together when en=1.
  - Bubbles are not collapsed.
  - Latency is exactly 3 cycles from acceptance to valid_out when unstalled.
- Stall: while en=0, every stage register and all outputs hold bit-stable. No beat is lost, duplicated or reordered.
- S1: b = sat32(acc_in[i] + bias[i]). The 33-bit sum is clamped to [-2^31, 2^31-1].
- S2: p = b * {0,scale[i]}. The product is signed, ACC_W+SCALE_W+1 bits, exact.
- S3:
  - If cfg_leaky and p<0: p' = p >>> 3 (slope 1/8, floor). Otherwise p' = p.
  - If shift>0: r = (p' + 2^(shift-1)) >>> shift. If shift=0: r = p'.
  - out = clamp(r, -128, 127), 2's complement in pixel_results[i].
- last_in is pipelined alongside its beat. last_out is valid only when valid_out=1.
- Config writes:
  - A write with cfg_we=1 updates bias[cfg_addr] and scale[cfg_addr] at the clock edge.
  - Writes, and changes to cfg_shift/cfg_leaky, are legal only while busy=0 && valid_in=0. The controller guarantees this; the block does not check it.
  - Writes take effect for the next accepted beat.
  - cfg_addr >= NUM_FILTERS is ignored.
- Simultaneous accept and emit under en=1 is a normal throughput cycle: 1 beat/cycle sustained.
- Reset mid-stream: in-flight beats are discarded, config reverts to reset values, ready_out=1 on the first edge after release.

Decomposition:
- quant_pkg holds:
  - localparams for ACC_W, SCALE_W, SHIFT_W, LEAKY_SHIFT=3, INT8_MIN/MAX.
  - typedef acc_t (signed ACC_W), prod_t (signed ACC_W+SCALE_W+1), pix_t (logic [7:0]).
  - Functions sat32 and sat_int8.
- Sub-module quant_lane: one lane's S1–S3 datapath with a shared en input. It is instantiated NUM_FILTERS times by generate. Valid/last/control logic stays in quant_array.

Test Plan:
- Reset: hold rst_n=0 -> valid_out=0, ready_out=1, busy=0, pixel_results all 0. Release -> still idle, no spurious valid.
- Basic: bias[0]=24, scale[0]=1, shift=4, acc_in[0]=1000, ready_in=1 -> 3 cycles later valid_out=1, pixel_results[0]=64 (1024+8>>4).
- Leaky and rounding: bias=0, scale=2, shift=2, leaky=1, acc=-800 -> product -1600, leaky -200, result -50 (0xCE). Same input with leaky=0 -> -128 (saturated).
- Saturation: acc=0x7FFFFFFF, bias=100, scale=1, shift=0 -> 127. acc=-100, bias=0, scale=1, shift=0 -> -100 (0x9C). acc=-1000 -> -128 (0x80).
- Back-pressure:
  - Stream 6 beats with distinct values and last_in on beat 6. Drop ready_in for 4 cycles after the first output.
  - valid_out stays 1 and data is stable while stalled. ready_out=0 during the stall.
  - All 6 results arrive in order, none lost or duplicated. last_out=1 only on beat 6. busy falls after the final handshake.
- Async reset mid-stream: assert rst_n=0 with 3 beats in flight and off the clock edge -> valid_out=0 immediately. After release, scale regs=1 and bias=0, verified by an acc=5, shift=0 beat producing 5.

Source files
------------

// File: rtl/quant_pkg.sv
// Shared widths, types and saturation helpers for the per-filter
// requantization stage.
package quant_pkg;
  localparam int ACC_W       = 32;
  localparam int SCALE_W     = 16;
  localparam int SHIFT_W     = 5;
  localparam int PROD_W      = ACC_W + SCALE_W + 1;
  localparam int LEAKY_SHIFT = 3;
  localparam int INT8_MIN    = -128;
  localparam int INT8_MAX    = 127;

  typedef logic signed [ACC_W-1:0]  acc_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic        [7:0]        pix_t;

  // Clamp a 33-bit signed sum back into the signed 32-bit range.
  function automatic acc_t sat32(input logic signed [ACC_W:0] s);
    if (s[ACC_W] != s[ACC_W-1])
      return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    return s[ACC_W-1:0];
  endfunction

  function automatic pix_t sat_int8(input prod_t r);
    if (r > prod_t'(INT8_MAX)) return pix_t'(INT8_MAX);
    if (r < prod_t'(INT8_MIN)) return pix_t'(INT8_MIN);
    return r[7:0];
  endfunction
endpackage

// File: rtl/quant_lane.sv
// One filter lane: bias + sat32 (S1), unsigned scale multiply (S2),
// leaky ReLU, rounding shift and int8 saturation (S3).
module quant_lane
  import quant_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_en,
  input  acc_t               i_acc,
  input  logic               i_cfg_we,
  input  acc_t               i_cfg_bias,
  input  logic [SCALE_W-1:0] i_cfg_scale,
  input  logic [SHIFT_W-1:0] i_shift,
  input  logic               i_leaky,
  output pix_t               o_pix
);
  acc_t               r_bias;
  logic [SCALE_W-1:0] r_scale;
  acc_t               r_b;
  prod_t              r_p;
  pix_t               r_pix;
  prod_t              w_leak;
  prod_t              w_half;
  prod_t              w_rnd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bias  <= '0;
      r_scale <= SCALE_W'(1);
    end else if (i_cfg_we) begin
      r_bias  <= i_cfg_bias;
      r_scale <= i_cfg_scale;
    end
  end

  // Rounding constant is 2^(shift-1); shift=0 passes the value through.
  always_comb begin
    w_leak = r_p;
    w_half = '0;
    if (i_leaky && (r_p < 0))
      w_leak = r_p >>> LEAKY_SHIFT;
    if (i_shift != '0)
      w_half = prod_t'(1) <<< (i_shift - SHIFT_W'(1));
    w_rnd = (w_leak + w_half) >>> i_shift;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b   <= '0;
      r_p   <= '0;
      r_pix <= '0;
    end else if (i_en) begin
      r_b   <= sat32({i_acc[ACC_W-1], i_acc} + {i_bias_ext(r_bias)});
      r_p   <= prod_t'(r_b) * prod_t'({1'b0, r_scale});
      r_pix <= sat_int8(w_rnd);
    end
  end

  function automatic logic [ACC_W:0] i_bias_ext(input acc_t b);
    return {b[ACC_W-1], b};
  endfunction

  assign o_pix = r_pix;
endmodule

// File: rtl/quant_array.sv
// Requantization array: NUM_FILTERS lanes sharing a 3-stage stall-able
// pipeline with valid/last tracking and ready back-pressure to the packer.
module quant_array
  import quant_pkg::*;
#(
  parameter  int NUM_FILTERS = 64,
  localparam int ADDR_W      = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_FILTERS*ACC_W-1:0] acc_in,
  input  logic                        valid_in,
  output logic                        ready_out,
  input  logic                        last_in,
  output logic [NUM_FILTERS*8-1:0]    pixel_results,
  output logic                        valid_out,
  input  logic                        ready_in,
  output logic                        last_out,
  input  logic                        cfg_we,
  input  logic [ADDR_W-1:0]           cfg_addr,
  input  logic [ACC_W-1:0]            cfg_bias,
  input  logic [SCALE_W-1:0]          cfg_scale,
  input  logic [SHIFT_W-1:0]          cfg_shift,
  input  logic                        cfg_leaky,
  output logic                        busy
);
  logic r_v1, r_v2, r_v3;
  logic r_l1, r_l2, r_l3;
  logic w_en;

  // All stages move in lockstep; bubbles travel with the beats.
  assign w_en = ready_in || !r_v3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
      r_l1 <= 1'b0;
      r_l2 <= 1'b0;
      r_l3 <= 1'b0;
    end else if (w_en) begin
      r_v1 <= valid_in;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
      r_l1 <= valid_in && last_in;
      r_l2 <= r_l1;
      r_l3 <= r_l2;
    end
  end

  for (genvar g = 0; g < NUM_FILTERS; g++) begin : g_lane
    logic w_we;
    // Out-of-range addresses match no lane and are dropped.
    assign w_we = cfg_we && (cfg_addr == ADDR_W'(g));

    quant_lane u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_en        (w_en),
      .i_acc       (acc_in[g*ACC_W +: ACC_W]),
      .i_cfg_we    (w_we),
      .i_cfg_bias  (cfg_bias),
      .i_cfg_scale (cfg_scale),
      .i_shift     (cfg_shift),
      .i_leaky     (cfg_leaky),
      .o_pix       (pixel_results[g*8 +: 8])
    );
  end

  assign ready_out = w_en;
  assign valid_out = r_v3;
  assign last_out  = r_l3;
  assign busy      = r_v1 || r_v2 || r_v3;
endmodule

// File: tb/tb_quant_array.sv
// Scoreboard bench for quant_array: expected int8 vectors are computed by a
// 64-bit integer model at acceptance and compared at the output handshake.
`timescale 1ns/1ps
module tb_quant_array;
  import quant_pkg::*;

  localparam int NF = 64;
  localparam int AW = $clog2(NF);
  localparam longint MAXA = 64'sd2147483647;
  localparam longint MINA = -64'sd2147483648;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NF*ACC_W-1:0]  acc_in = '0;
  logic                 valid_in = 1'b0;
  logic                 ready_out;
  logic                 last_in = 1'b0;
  logic [NF*8-1:0]      pixel_results;
  logic                 valid_out;
  logic                 ready_in = 1'b1;
  logic                 last_out;
  logic                 cfg_we = 1'b0;
  logic [AW-1:0]        cfg_addr = '0;
  logic [ACC_W-1:0]     cfg_bias = '0;
  logic [SCALE_W-1:0]   cfg_scale = '0;
  logic [SHIFT_W-1:0]   cfg_shift = '0;
  logic                 cfg_leaky = 1'b0;
  logic                 busy;

  always #5 clk = ~clk;

  quant_array #(.NUM_FILTERS(NF)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .acc_in        (acc_in),
    .valid_in      (valid_in),
    .ready_out     (ready_out),
    .last_in       (last_in),
    .pixel_results (pixel_results),
    .valid_out     (valid_out),
    .ready_in      (ready_in),
    .last_out      (last_out),
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_bias      (cfg_bias),
    .cfg_scale     (cfg_scale),
    .cfg_shift     (cfg_shift),
    .cfg_leaky     (cfg_leaky),
    .busy          (busy)
  );

  int total = 0;
  int bad   = 0;
  int n_out = 0;

  task automatic check(input string tag, input logic [NF*8-1:0] got, input logic [NF*8-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  longint m_bias[NF];
  longint m_scale[NF];

  function automatic logic [7:0] model_lane(input longint a, input longint b, input longint s,
                                           input int sh, input bit lk);
    longint v;
    longint r;
    v = a + b;
    if (v > MAXA) v = MAXA;
    else if (v < MINA) v = MINA;
    v = v * s;
    if (lk && v < 0) v = v >>> 3;
    r = (sh > 0) ? ((v + (longint'(1) <<< (sh - 1))) >>> sh) : v;
    if (r > 127) r = 127;
    else if (r < -128) r = -128;
    return r[7:0];
  endfunction

  function automatic logic [NF*8-1:0] model_vec(input logic [NF*ACC_W-1:0] a);
    logic [NF*8-1:0] e;
    acc_t ai;
    for (int i = 0; i < NF; i++) begin
      ai = a[i*ACC_W +: ACC_W];
      e[i*8 +: 8] = model_lane(longint'(ai), m_bias[i], m_scale[i], int'(cfg_shift), cfg_leaky);
    end
    return e;
  endfunction

  function automatic logic [NF*ACC_W-1:0] vec0(input longint a0);
    logic [NF*ACC_W-1:0] v;
    v = '0;
    v[ACC_W-1:0] = ACC_W'(a0);
    return v;
  endfunction

  function automatic logic [NF*ACC_W-1:0] vec_all(input longint a);
    logic [NF*ACC_W-1:0] v;
    for (int i = 0; i < NF; i++) v[i*ACC_W +: ACC_W] = ACC_W'(a);
    return v;
  endfunction

  typedef struct {
    logic [NF*8-1:0] pix;
    logic            last;
  } exp_t;

  exp_t q[$];
  exp_t sb_e;

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_in && ready_out)
        q.push_back('{model_vec(acc_in), last_in});
      if (valid_out && ready_in) begin
        check("sb_nonempty", (q.size() != 0), 1);
        if (q.size() != 0) begin
          sb_e = q.pop_front();
          check("sb_pix", pixel_results, sb_e.pix);
          check("sb_last", last_out, sb_e.last);
          n_out++;
        end
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < NF; i++) begin
      m_bias[i]  = 0;
      m_scale[i] = 1;
    end
  endtask

  task automatic cfg_write(input int idx, input longint b, input longint s);
    cfg_we    = 1'b1;
    cfg_addr  = AW'(idx);
    cfg_bias  = ACC_W'(b);
    cfg_scale = SCALE_W'(s);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    m_bias[idx]  = b;
    m_scale[idx] = s;
  endtask

  task automatic drive_beat(input logic [NF*ACC_W-1:0] a, input logic l);
    bit took;
    took     = 1'b0;
    acc_in   = a;
    last_in  = l;
    valid_in = 1'b1;
    for (int k = 0; k < 100 && !took; k++) begin
      @(negedge clk);
      took = ready_out;
      @(posedge clk); #1;
    end
    check("accept", took, 1);
    valid_in = 1'b0;
    last_in  = 1'b0;
  endtask

  task automatic run_one(input logic [NF*ACC_W-1:0] a, output logic [7:0] lane0);
    int lat;
    lat = 1;
    drive_beat(a, 1'b0);
    while (!valid_out && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, 3);
    lane0 = pixel_results[7:0];
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 500us");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    int k;
    model_reset();

    rst_n = 1'b0;
    #23;
    check("rst_valid", valid_out, 0);
    check("rst_ready", ready_out, 1);
    check("rst_busy", busy, 0);
    check("rst_pix", pixel_results, '0);
    check("rst_last", last_out, 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_valid", valid_out, 0);
    check("idle_ready", ready_out, 1);

    cfg_write(0, 24, 1);
    cfg_shift = 4; cfg_leaky = 1'b0;
    run_one(vec0(1000), r);
    check("basic", r, 8'd64);

    cfg_write(0, 0, 2);
    cfg_shift = 2; cfg_leaky = 1'b1;
    run_one(vec0(-800), r);
    check("leaky_round", r, 8'hCE);
    cfg_leaky = 1'b0;
    run_one(vec0(-800), r);
    check("noleaky_sat", r, 8'h80);

    cfg_write(0, 100, 1);
    cfg_shift = 0;
    run_one(vec0(64'h7FFFFFFF), r);
    check("sat_pos", r, 8'h7F);
    cfg_write(0, 0, 1);
    run_one(vec0(-100), r);
    check("neg_pass", r, 8'h9C);
    run_one(vec0(-1000), r);
    check("sat_neg", r, 8'h80);

    for (int i = 0; i < NF; i++) cfg_write(i, i * 1000 - 30000, i * 37 + 1);
    cfg_shift = 16; cfg_leaky = 1'b1;
    n_out = 0;
    fork
      begin : drv
        logic [NF*ACC_W-1:0] a;
        for (int b = 0; b < 6; b++) begin
          for (int i = 0; i < NF; i++)
            a[i*ACC_W +: ACC_W] = ACC_W'(int'($urandom_range(0, 200000)) - 100000 + b * 7000);
          drive_beat(a, (b == 5));
        end
      end
      begin : stall
        logic [NF*8-1:0] snap;
        int w;
        w = 0;
        while (!valid_out && w < 50) begin
          @(posedge clk); #1;
          w++;
        end
        check("bp_first_out", valid_out, 1);
        @(posedge clk); #1;
        ready_in = 1'b0;
        snap = pixel_results;
        repeat (4) begin
          @(negedge clk);
          check("stall_valid", valid_out, 1);
          check("stall_data", pixel_results, snap);
          check("stall_ready", ready_out, 0);
        end
        @(posedge clk); #1;
        ready_in = 1'b1;
      end
    join
    k = 0;
    while (busy && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("bp_count", n_out, 6);
    check("bp_drained", q.size(), 0);
    check("bp_busy", busy, 0);

    cfg_write(0, 7, 3);
    cfg_shift = 1; cfg_leaky = 1'b0;
    drive_beat(vec_all(11), 1'b0);
    drive_beat(vec_all(22), 1'b0);
    drive_beat(vec_all(33), 1'b0);
    check("mid_inflight", valid_out, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", valid_out, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", ready_out, 1);
    check("mid_rst_pix", pixel_results, '0);
    q.delete();
    model_reset();
    cfg_shift = 0;
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", ready_out, 1);
    run_one(vec_all(5), r);
    check("post_rst_cfg", r, 8'd5);
    repeat (3) @(posedge clk);
    #1;
    check("final_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
